// File: rtl/fir_stream_param.sv
// fir_stream_param: streaming FIR filter with one multiplier that is shared across all taps.
//
// Each sample that is accepted shifts into the delay line. The block then runs TAPS
// multiply-accumulate cycles. It registers the sum and offers it on the output handshake.
// Only one sample is in flight at a time, so input and output never overlap.
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   rst        asynchronous active-high reset
//   in_valid   sample offered
//   in_ready   block accepts a sample (IDLE only; held low while flush is high)
//   in_data    sample, DW bits, unsigned
//   out_valid  result offered
//   out_ready  consumer accepts the result
//   out_data   result, OW bits, unsigned; wide enough that it cannot overflow
//   coef_we    coefficient write request (honoured in IDLE only)
//   coef_addr  tap index of the write; writes with coef_addr >= TAPS are dropped
//   coef_data  coefficient value, CW bits, unsigned
//   coef_ack   one-cycle pulse after an accepted write
//   flush      zeroes the delay line when the block is idle
module fir_stream_param #(
   parameter int unsigned DW   = 8,
   parameter int unsigned CW   = 8,
   parameter int unsigned TAPS = 8,
   localparam int unsigned AW  = $clog2(TAPS),
   localparam int unsigned OW  = DW + CW + AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [CW-1:0] coef_data,
   output logic          coef_ack,
   input  logic          flush
);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   localparam logic [AW:0]   TapsW   = (AW + 1)'(TAPS);
   localparam logic [AW-1:0] LastIdx = AW'(TAPS - 1);

   state_e           state_q, state_d;
   logic [DW-1:0]    x_q [TAPS];
   logic [CW-1:0]    c_q [TAPS];
   logic [OW-1:0]    acc_q;
   logic [AW-1:0]    idx_q;
   logic             out_valid_q;
   logic [OW-1:0]    out_data_q;
   logic             coef_ack_q;

   logic             in_accept;
   logic             coef_ok;
   logic             mac_last;
   logic             out_fire;
   logic [DW+CW-1:0] prod;

   assign in_ready  = (state_q == StIdle) && !flush;
   assign in_accept = in_valid && in_ready;
   // The zero-extended compare catches out-of-range addresses when TAPS is not a power of 2.
   assign coef_ok   = (state_q == StIdle) && coef_we && ({1'b0, coef_addr} < TapsW);
   assign mac_last  = (idx_q == LastIdx);
   assign out_fire  = out_valid_q && out_ready;
   assign prod      = x_q[idx_q] * c_q[idx_q];

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_accept) state_d = StMac;
         StMac:   if (mac_last)  state_d = StOut;
         StOut:   if (out_fire)  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            x_q[k] <= '0;
            c_q[k] <= CW'(k + 1);
         end
         acc_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         coef_ack_q  <= 1'b0;
      end else begin
         coef_ack_q <= coef_ok;
         // A write is registered on the accept edge, so the MAC that follows already
         // reads the new coefficient.
         if (coef_ok) c_q[coef_addr] <= coef_data;

         if (state_q == StIdle) begin
            if (flush) begin
               for (int k = 0; k < int'(TAPS); k++) x_q[k] <= '0;
            end else if (in_accept) begin
               for (int k = 1; k < int'(TAPS); k++) x_q[k] <= x_q[k-1];
               x_q[0] <= in_data;
               acc_q  <= '0;
               idx_q  <= '0;
            end
         end

         if (state_q == StMac) begin
            acc_q <= acc_q + OW'(prod);
            idx_q <= mac_last ? '0 : idx_q + AW'(1);
         end

         // The first OUT cycle copies acc into the output register. From then on,
         // out_valid and out_data come straight from flops and stay stable under
         // backpressure.
         if (state_q == StOut) begin
            if (!out_valid_q) begin
               out_valid_q <= 1'b1;
               out_data_q  <= acc_q;
            end else if (out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign coef_ack  = coef_ack_q;

endmodule

// File: tb/tb_fir_stream_param.sv
module tb_fir_stream_param;

   localparam int TAPS  = 8;
   localparam int TAPS5 = 5;
   localparam int OW    = 19;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready, coef_we, coef_ack, flush;
   logic [7:0]    in_data, coef_data;
   logic [2:0]    coef_addr;
   logic [OW-1:0] out_data;

   logic          in_valid5, in_ready5, out_valid5, out_ready5, coef_we5, coef_ack5, flush5;
   logic [7:0]    in_data5, coef_data5;
   logic [2:0]    coef_addr5;
   logic [OW-1:0] out_data5;

   always #5 clk = ~clk;

   fir_stream_param #(.DW(8), .CW(8), .TAPS(TAPS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .coef_ack(coef_ack), .flush(flush)
   );

   fir_stream_param #(.DW(8), .CW(8), .TAPS(TAPS5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
      .coef_we(coef_we5), .coef_addr(coef_addr5), .coef_data(coef_data5),
      .coef_ack(coef_ack5), .flush(flush5)
   );

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Transaction-level model of the 8-tap instance: one result in flight, due TAPS+1
   // edges after its accept edge, computed directly as sum c[k]*x[k].
   int            cyc = 0;
   logic          m_busy, m_ack;
   int            m_valid_at;
   logic [OW-1:0] m_exp;
   logic [7:0]    m_x [TAPS];
   logic [7:0]    m_c [TAPS];
   logic [7:0]    nx [TAPS];
   logic [7:0]    nc [TAPS];
   logic [OW-1:0] sum;
   logic [OW-1:0] got [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < TAPS; k++) begin
            m_x[k] <= 8'd0;
            m_c[k] <= 8'(k + 1);
         end
         m_busy     <= 1'b0;
         m_ack      <= 1'b0;
         m_valid_at <= 0;
         m_exp      <= '0;
      end else begin
         cyc <= cyc + 1;
         nc = m_c;
         nx = m_x;
         m_ack <= !m_busy && coef_we && (int'(coef_addr) < TAPS);
         if (!m_busy && coef_we && (int'(coef_addr) < TAPS)) nc[coef_addr] = coef_data;
         if (!m_busy && flush) begin
            for (int k = 0; k < TAPS; k++) nx[k] = 8'd0;
         end else if (!m_busy && in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) nx[k] = nx[k-1];
            nx[0] = in_data;
            sum = '0;
            for (int k = 0; k < TAPS; k++) sum = sum + OW'(nc[k]) * OW'(nx[k]);
            m_exp      <= sum;
            m_busy     <= 1'b1;
            m_valid_at <= cyc + 1 + TAPS + 1;
         end
         if (m_busy && cyc >= m_valid_at && out_ready) begin
            m_busy <= 1'b0;
            got.push_back(out_data);
         end
         m_c <= nc;
         m_x <= nx;
      end
   end

   always @(negedge clk) begin
      logic ev;
      ev = m_busy && (cyc >= m_valid_at);
      chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !flush});
      chk("coef_ack", {31'd0, coef_ack}, {31'd0, m_ack});
      if (ev) chk("out_data", 32'(out_data), 32'(m_exp));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy; i++) step();
      if (m_busy) begin
         nvec++;
         nfail++;
         $display("FAIL wait_idle: busy after 40 cycles, expected idle");
      end
   endtask

   task automatic send(input logic [7:0] d, input int hold);
      wait_idle();
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_data   = d;
      step();
      in_valid  = 1'b0;
      if (hold > 0) begin
         for (int i = 0; i < TAPS + 5 && !(m_busy && cyc >= m_valid_at); i++) step();
         repeat (hold) step();
         out_ready = 1'b1;
      end
      wait_idle();
   endtask

   task automatic last_is(input string name, input int exp);
      chk(name, got.size() > 0 ? 32'(got[got.size()-1]) : 32'bx, 32'(exp));
   endtask

   task automatic coef_write(input logic [2:0] a, input logic [7:0] d);
      wait_idle();
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      step();
      coef_we = 1'b0;
      chk("coef_ack_pulse", {31'd0, coef_ack}, 32'd1);
      step();
      chk("coef_ack_drop", {31'd0, coef_ack}, 32'd0);
   endtask

   task automatic send5(input logic [7:0] d, input int exp, input string name);
      int n;
      in_valid5 = 1'b1;
      in_data5  = d;
      step();
      in_valid5 = 1'b0;
      n = 0;
      while (!out_valid5 && n < 20) begin
         step();
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(TAPS5 + 1));
      chk(name, 32'(out_data5), 32'(exp));
      step();
      chk({name, "_in_ready"}, {31'd0, in_ready5}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      automatic int imp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
      int n;
      rst = 1'b1;
      in_valid = 0; in_data = 0; out_ready = 1; coef_we = 0; coef_addr = 0; coef_data = 0;
      flush = 0;
      in_valid5 = 0; in_data5 = 0; out_ready5 = 1; coef_we5 = 0; coef_addr5 = 0;
      coef_data5 = 0; flush5 = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_coef_ack", {31'd0, coef_ack}, 32'd0);
      step();
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Impulse through default coefficients.
      got.delete();
      send(8'd1, 0);
      repeat (8) send(8'd0, 0);
      chk("impulse_count", 32'(got.size()), 32'd9);
      for (int i = 0; i < got.size() && i < 9; i++) chk("impulse", 32'(got[i]), 32'(imp[i]));

      // Largest possible inputs.
      got.delete();
      repeat (9) send(8'd255, 0);
      chk("max_count", 32'(got.size()), 32'd9);
      if (got.size() == 9) begin
         chk("max_first", 32'(got[0]), 32'd255);
         chk("max_ninth", 32'(got[8]), 32'd9180);
      end

      // Backpressure: 10 cycles of out_ready low while OUT.
      send(8'd0, 10);
      last_is("backpressure", 8925);

      // Flush clears old samples; an input offered during flush is ignored.
      send(8'd5, 0);
      send(8'd5, 0);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'd7;
      step();
      step();
      flush = 1'b0; in_valid = 1'b0;
      send(8'd1, 0);
      last_is("flush_impulse", 1);

      // Coefficient write, then impulse.
      flush = 1'b1; step(); flush = 1'b0;
      coef_write(3'd0, 8'd10);
      send(8'd1, 0);
      last_is("coef_c0_impulse", 10);

      // Write that coincides with an accept is used by that same sample.
      coef_we = 1'b1; coef_addr = 3'd1; coef_data = 8'd3;
      in_valid = 1'b1; in_data = 8'd0;
      step();
      coef_we = 1'b0; in_valid = 1'b0;
      wait_idle();
      last_is("coef_same_cycle", 3);

      // Write during MAC is dropped.
      in_valid = 1'b1; in_data = 8'd2;
      step();
      in_valid = 1'b0;
      step();
      step();
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd99;
      step();
      coef_we = 1'b0;
      chk("coef_mac_no_ack", {31'd0, coef_ack}, 32'd0);
      wait_idle();
      last_is("coef_mac_result", 23);
      flush = 1'b1; step(); flush = 1'b0;
      send(8'd1, 0);
      last_is("coef_mac_unchanged", 10);

      // Reset in MAC cycle 3: the result is abandoned, defaults return.
      got.delete();
      in_valid = 1'b1; in_data = 8'd9;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_mac_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mac_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mac_no_output", 32'(got.size()), 32'd0);
      send(8'd1, 0);
      last_is("rst_mac_impulse", 1);

      // Five-tap instance: address range, ack behaviour, latency.
      coef_we5 = 1'b1; coef_addr5 = 3'd6; coef_data5 = 8'd50;
      step();
      coef_we5 = 1'b0;
      chk("t5_oob_no_ack", {31'd0, coef_ack5}, 32'd0);
      step();
      coef_we5 = 1'b1; coef_addr5 = 3'd4; coef_data5 = 8'd20;
      step();
      coef_we5 = 1'b0;
      chk("t5_ack", {31'd0, coef_ack5}, 32'd1);
      step();
      chk("t5_ack_drop", {31'd0, coef_ack5}, 32'd0);
      in_valid5 = 1'b1; in_data5 = 8'd1;
      step();
      in_valid5 = 1'b0;
      step();
      coef_we5 = 1'b1; coef_addr5 = 3'd0; coef_data5 = 8'd77;
      step();
      coef_we5 = 1'b0;
      chk("t5_mac_no_ack", {31'd0, coef_ack5}, 32'd0);
      n = 0;
      while (!out_valid5 && n < 20) begin
         step();
         n++;
      end
      chk("t5_impulse_c0", 32'(out_data5), 32'd1);
      step();
      send5(8'd0, 2, "t5_c1");
      send5(8'd0, 3, "t5_c2");
      send5(8'd0, 4, "t5_c3");
      send5(8'd0, 20, "t5_c4");
      send5(8'd0, 0, "t5_drained");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
